// File: rtl/video_timing_gen.sv
// Raster timing generator: FP/SYNC/BP/ACTIVE line and frame counters with double-buffered config.
// Define VTG_PATTERN_EN to add an 8-bar colour test pattern on rgb; otherwise rgb is tied to 0.
module video_timing_gen #(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_active,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_hs_pol,
    input  logic          cfg_vs_pol,
    input  logic          cfg_load,
    input  logic          enable,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          sof,
    output logic          eol,
    output logic          cfg_err,
    output logic [23:0]   rgb
);

    typedef struct packed {
        logic [CW-1:0] h_act;
        logic [CW-1:0] h_fp;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_bp;
        logic [CW-1:0] v_act;
        logic [CW-1:0] v_fp;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_bp;
        logic          hs_pol;
        logic          vs_pol;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{
        h_act: CW'(1024), h_fp: CW'(24), h_sync: CW'(136), h_bp: CW'(160),
        v_act: CW'(768),  v_fp: CW'(3),  v_sync: CW'(6),   v_bp: CW'(29),
        hs_pol: 1'b0, vs_pol: 1'b0
    };

    localparam logic [CW+1:0] MAX_TOT = {2'b00, {CW{1'b1}}};

    function automatic logic [CW-1:0] fix_zero(input logic [CW-1:0] v);
        return (v == '0) ? CW'(1) : v;
    endfunction

    cfg_t          sh_r, pend_r, ld_s, pend_n_s;
    logic [CW+1:0] ld_h_tot_s, ld_v_tot_s;
    logic          ld_fits_s, apply_s, frame_end_s;
    logic [CW-1:0] h_cnt_r, v_cnt_r, h_nxt_s, v_nxt_s;
    logic [CW-1:0] h_sync_end_s, h_blank_s, h_last_s;
    logic [CW-1:0] v_sync_end_s, v_blank_s, v_last_s;
    logic          hsync_s, vsync_s, de_s, sof_s, eol_s;
    logic [CW-1:0] x_s, y_s;

    // Sanitise the incoming config and decide whether it fits the counters.
    always_comb begin
        ld_s.h_act  = fix_zero(cfg_h_active);
        ld_s.h_fp   = fix_zero(cfg_h_fp);
        ld_s.h_sync = fix_zero(cfg_h_sync);
        ld_s.h_bp   = fix_zero(cfg_h_bp);
        ld_s.v_act  = fix_zero(cfg_v_active);
        ld_s.v_fp   = fix_zero(cfg_v_fp);
        ld_s.v_sync = fix_zero(cfg_v_sync);
        ld_s.v_bp   = fix_zero(cfg_v_bp);
        ld_s.hs_pol = cfg_hs_pol;
        ld_s.vs_pol = cfg_vs_pol;
        ld_h_tot_s  = {2'b00, ld_s.h_act} + {2'b00, ld_s.h_fp} + {2'b00, ld_s.h_sync} + {2'b00, ld_s.h_bp};
        ld_v_tot_s  = {2'b00, ld_s.v_act} + {2'b00, ld_s.v_fp} + {2'b00, ld_s.v_sync} + {2'b00, ld_s.v_bp};
        ld_fits_s   = (ld_h_tot_s <= MAX_TOT) && (ld_v_tot_s <= MAX_TOT);
        if (cfg_load && ld_fits_s) begin
            pend_n_s = ld_s;
        end else begin
            pend_n_s = pend_r;
        end
        apply_s = !enable || frame_end_s;
    end

    // Pending/shadow config registers; a load landing on frame end is applied directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_r    <= DEF_CFG;
            pend_r  <= DEF_CFG;
            cfg_err <= 1'b0;
        end else begin
            pend_r <= pend_n_s;
            if (apply_s) begin
                sh_r <= pend_n_s;
            end
            if (cfg_load) begin
                cfg_err <= !ld_fits_s;
            end
        end
    end

    // Region boundaries derived from the active config; totals are known to fit CW bits.
    always_comb begin
        h_sync_end_s = sh_r.h_fp + sh_r.h_sync;
        h_blank_s    = h_sync_end_s + sh_r.h_bp;
        h_last_s     = h_blank_s + sh_r.h_act - CW'(1);
        v_sync_end_s = sh_r.v_fp + sh_r.v_sync;
        v_blank_s    = v_sync_end_s + sh_r.v_bp;
        v_last_s     = v_blank_s + sh_r.v_act - CW'(1);
        frame_end_s  = enable && (h_cnt_r == h_last_s) && (v_cnt_r == v_last_s);
    end

    // Next counter position; disabled means parked at the frame origin.
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (!enable) begin
            h_nxt_s = '0;
            v_nxt_s = '0;
        end else if (h_cnt_r == h_last_s) begin
            h_nxt_s = '0;
            if (v_cnt_r == v_last_s) begin
                v_nxt_s = '0;
            end else begin
                v_nxt_s = v_cnt_r + CW'(1);
            end
        end else begin
            h_nxt_s = h_cnt_r + CW'(1);
        end
    end

    // Pixel and line counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else begin
            h_cnt_r <= h_nxt_s;
            v_cnt_r <= v_nxt_s;
        end
    end

    // Decode the current counter position into raster controls.
    always_comb begin
        hsync_s = (h_cnt_r >= sh_r.h_fp) && (h_cnt_r < h_sync_end_s);
        vsync_s = (v_cnt_r >= sh_r.v_fp) && (v_cnt_r < v_sync_end_s);
        de_s    = (h_cnt_r >= h_blank_s) && (v_cnt_r >= v_blank_s);
        if (de_s) begin
            x_s = h_cnt_r - h_blank_s;
            y_s = v_cnt_r - v_blank_s;
        end else begin
            x_s = '0;
            y_s = '0;
        end
        sof_s = de_s && (h_cnt_r == h_blank_s) && (v_cnt_r == v_blank_s);
        eol_s = de_s && (h_cnt_r == h_last_s);
    end

    // Output registers, one clock behind the counter state they decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs  <= 1'b0;
            vs  <= 1'b0;
            de  <= 1'b0;
            x   <= '0;
            y   <= '0;
            sof <= 1'b0;
            eol <= 1'b0;
        end else if (!enable) begin
            hs  <= ~sh_r.hs_pol;
            vs  <= ~sh_r.vs_pol;
            de  <= 1'b0;
            x   <= '0;
            y   <= '0;
            sof <= 1'b0;
            eol <= 1'b0;
        end else begin
            hs  <= hsync_s ? sh_r.hs_pol : ~sh_r.hs_pol;
            vs  <= vsync_s ? sh_r.vs_pol : ~sh_r.vs_pol;
            de  <= de_s;
            x   <= x_s;
            y   <= y_s;
            sof <= sof_s;
            eol <= eol_s;
        end
    end

`ifdef VTG_PATTERN_EN
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    logic [CW-1:0] bar_w_s, bar_cnt_r, bar_cnt_n_s;
    logic [2:0]    bar_idx_r, bar_idx_n_s;

    // Bar tracker follows h_cnt so bar_idx_r always belongs to the pixel being decoded.
    always_comb begin
        bar_w_s     = ((sh_r.h_act >> 3) == '0) ? CW'(1) : (sh_r.h_act >> 3);
        bar_cnt_n_s = bar_cnt_r;
        bar_idx_n_s = bar_idx_r;
        if (h_nxt_s <= h_blank_s) begin
            bar_cnt_n_s = '0;
            bar_idx_n_s = 3'd0;
        end else if (bar_cnt_r == bar_w_s - CW'(1)) begin
            bar_cnt_n_s = '0;
            bar_idx_n_s = (bar_idx_r == 3'd7) ? 3'd7 : bar_idx_r + 3'd1;
        end else begin
            bar_cnt_n_s = bar_cnt_r + CW'(1);
        end
    end

    // Bar tracker state and registered pixel colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_cnt_r <= '0;
            bar_idx_r <= 3'd0;
            rgb       <= 24'h000000;
        end else begin
            bar_cnt_r <= bar_cnt_n_s;
            bar_idx_r <= bar_idx_n_s;
            rgb       <= (enable && de_s) ? bar_colour(bar_idx_r) : 24'h000000;
        end
    end
`else
    assign rgb = 24'h000000;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: small 7x5 raster, config reload/reject, enable abort, pattern.
module tb_video_timing_gen;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [CW-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
    logic          cfg_hs_pol, cfg_vs_pol, cfg_load, enable;
    logic          hs, vs, de, sof, eol, cfg_err;
    logic [CW-1:0] x, y;
    logic [23:0]   rgb;
    logic [52:0]   act_vec;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    video_timing_gen #(.CW(CW)) dut (
        .clk(clk), .rst(rst),
        .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol), .cfg_load(cfg_load), .enable(enable),
        .hs(hs), .vs(vs), .de(de), .x(x), .y(y), .sof(sof), .eol(eol), .cfg_err(cfg_err), .rgb(rgb)
    );

    assign act_vec = {hs, vs, de, sof, eol, x, y, rgb};

    // Reference for the H h_act/1/1/1, V 2/1/1/1, polarity-0 raster at output cycle t.
    function automatic logic [52:0] exp_vec(input int h_act, input int t);
        int h_tot, p, h, v, xe, ye, bw, idx;
        logic hs_e, vs_e, de_e, sof_e, eol_e;
        logic [23:0] rgb_e;
        h_tot = h_act + 3;
        p     = t % (h_tot * 5);
        h     = p % h_tot;
        v     = p / h_tot;
        hs_e  = (h == 1) ? 1'b0 : 1'b1;
        vs_e  = (v == 1) ? 1'b0 : 1'b1;
        de_e  = (h >= 3) && (v >= 3);
        xe    = de_e ? h - 3 : 0;
        ye    = de_e ? v - 3 : 0;
        sof_e = de_e && (xe == 0) && (ye == 0);
        eol_e = de_e && (xe == h_act - 1);
        rgb_e = 24'h000000;
`ifdef VTG_PATTERN_EN
        if (de_e) begin
            bw  = (h_act / 8 == 0) ? 1 : h_act / 8;
            idx = xe / bw;
            if (idx > 7) idx = 7;
            case (idx)
                0:       rgb_e = 24'hFFFFFF;
                1:       rgb_e = 24'hFFFF00;
                2:       rgb_e = 24'h00FFFF;
                3:       rgb_e = 24'h00FF00;
                4:       rgb_e = 24'hFF00FF;
                5:       rgb_e = 24'hFF0000;
                6:       rgb_e = 24'h0000FF;
                default: rgb_e = 24'h000000;
            endcase
        end
`endif
        return {hs_e, vs_e, de_e, sof_e, eol_e, 12'(xe), 12'(ye), rgb_e};
    endfunction

    // Disable, load the small raster (applies at once while disabled), then enable.
    task automatic start_fresh(input int h_act, input int h_fp);
        @(negedge clk);
        enable       = 1'b0;
        cfg_h_active = 12'(h_act);
        cfg_h_fp     = 12'(h_fp);
        cfg_h_sync   = 12'd1;
        cfg_h_bp     = 12'd1;
        cfg_v_active = 12'd2;
        cfg_v_fp     = 12'd1;
        cfg_v_sync   = 12'd1;
        cfg_v_bp     = 12'd1;
        cfg_hs_pol   = 1'b0;
        cfg_vs_pol   = 1'b0;
        cfg_load     = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        enable   = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] e3;
        rst = 1'b1; enable = 1'b0; cfg_load = 1'b0;
        cfg_h_active = 12'd0; cfg_h_fp = 12'd0; cfg_h_sync = 12'd0; cfg_h_bp = 12'd0;
        cfg_v_active = 12'd0; cfg_v_fp = 12'd0; cfg_v_sync = 12'd0; cfg_v_bp = 12'd0;
        cfg_hs_pol = 1'b0; cfg_vs_pol = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({act_vec, cfg_err} !== 54'd0) begin
            failures++;
            $display("FAIL reset_state got %h want 0", {act_vec, cfg_err});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({hs, vs, de} !== 3'b110) begin
            failures++;
            $display("FAIL reset_release hs,vs,de got %b want 110", {hs, vs, de});
        end
        enable = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            e3 = {(k >= 24 && k < 160) ? 1'b0 : 1'b1, 1'b1, 1'b0};
            checks++;
            if ({hs, vs, de} !== e3) begin
                failures++;
                $display("FAIL default_timing k=%0d hs,vs,de got %b want %b", k, {hs, vs, de}, e3);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_small_frame();
        int n_sof = 0, n_de = 0, n_hs = 0, n_eol = 0;
        start_fresh(4, 1);
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            checks++;
            if (act_vec !== exp_vec(4, k)) begin
                failures++;
                $display("FAIL small_frame k=%0d got %h want %h", k, act_vec, exp_vec(4, k));
            end
            n_sof += int'(sof); n_de += int'(de); n_hs += int'(!hs); n_eol += int'(eol);
        end
        checks++;
        if ({n_sof, n_de, n_hs, n_eol} !== {32'd2, 32'd16, 32'd10, 32'd4}) begin
            failures++;
            $display("FAIL small_counts sof/de/hslow/eol got %0d/%0d/%0d/%0d want 2/16/10/4",
                     n_sof, n_de, n_hs, n_eol);
        end
    endtask

    task automatic test_reload();
        int n_de = 0;
        start_fresh(4, 1);
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            checks++;
            if (act_vec !== exp_vec(4, k)) begin
                failures++;
                $display("FAIL reload_old k=%0d got %h want %h", k, act_vec, exp_vec(4, k));
            end
            if (k == 10) begin cfg_h_active = 12'd8; cfg_load = 1'b1; end
            if (k == 11) cfg_load = 1'b0;
        end
        for (int k = 0; k < 55; k++) begin
            @(negedge clk);
            checks++;
            if (act_vec !== exp_vec(8, k)) begin
                failures++;
                $display("FAIL reload_new k=%0d got %h want %h", k, act_vec, exp_vec(8, k));
            end
            n_de += int'(de);
        end
        checks++;
        if (n_de !== 16) begin
            failures++;
            $display("FAIL reload_de_count got %0d want 16", n_de);
        end
    endtask

    task automatic test_cfg_err();
        logic e_err;
        start_fresh(8, 1);
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            e_err = (k >= 6) && (k < 61);
            checks++;
            if (act_vec !== exp_vec(8, k)) begin
                failures++;
                $display("FAIL cfg_err_timing k=%0d got %h want %h", k, act_vec, exp_vec(8, k));
            end
            checks++;
            if (cfg_err !== e_err) begin
                failures++;
                $display("FAIL cfg_err_flag k=%0d got %b want %b", k, cfg_err, e_err);
            end
            if (k == 5)  begin cfg_h_active = 12'd4095; cfg_load = 1'b1; end
            if (k == 6)  begin cfg_h_active = 12'd8;    cfg_load = 1'b0; end
            if (k == 60) cfg_load = 1'b1;
            if (k == 61) cfg_load = 1'b0;
        end
    endtask

    task automatic test_enable_abort();
        int found_at = 0;
        start_fresh(4, 1);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            checks++;
            if (act_vec !== exp_vec(4, k)) begin
                failures++;
                $display("FAIL abort_pre k=%0d got %h want %h", k, act_vec, exp_vec(4, k));
            end
        end
        enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (act_vec !== {5'b11000, 48'd0}) begin
                failures++;
                $display("FAIL abort_idle k=%0d got %h want %h", k, act_vec, {5'b11000, 48'd0});
            end
        end
        enable = 1'b1;
        for (int n = 1; n <= 100 && found_at == 0; n++) begin
            @(negedge clk);
            if (sof) found_at = n;
        end
        checks++;
        if (found_at !== 25) begin
            failures++;
            $display("FAIL reenable_sof_latency got %0d want 25 (0 = timeout)", found_at);
        end
    endtask

    task automatic test_pattern();
        start_fresh(16, 0);
        for (int k = 0; k < 95; k++) begin
            @(negedge clk);
            checks++;
            if (act_vec !== exp_vec(16, k)) begin
                failures++;
                $display("FAIL pattern k=%0d got %h want %h", k, act_vec, exp_vec(16, k));
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_small_frame();
        test_reload();
        test_cfg_err();
        test_enable_abort();
        test_pattern();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter CW, default 12, counter/coordinate/config field width.
REQ-002 SHALL have ports: clk in 1 pixel clock; rst in 1 reset (asynchronous, active-high).
REQ-003 SHALL have ports: cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp in CW horizontal timing in pixels.
REQ-004 SHALL have ports: cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp in CW vertical timing in lines.
REQ-005 SHALL have ports: cfg_hs_pol, cfg_vs_pol in 1 sync polarity (1 positive); cfg_load in 1 capture-config pulse; enable in 1 run.
REQ-006 SHALL have outputs: hs, vs, de out 1; x, y out CW active coordinates; sof out 1; eol out 1; cfg_err out 1; rgb out 24.

Function
REQ-007 Line order SHALL be FP, SYNC, BP, ACTIVE; h_cnt runs 0..H_TOTAL-1, H_TOTAL = sum of four horizontal fields; same ordering for v_cnt in lines.
REQ-008 v_cnt SHALL increment when h_cnt == H_TOTAL-1, wrapping 0 after V_TOTAL-1; vs edges SHALL align to line start (h_cnt 0).
REQ-009 All outputs SHALL be registered, exactly 1 clk after the counter state they decode.
REQ-010 hs SHALL equal cfg_hs_pol for h_cnt in [H_FP, H_FP+H_SYNC), else inverse; vs likewise for v_cnt in [V_FP, V_FP+V_SYNC).
REQ-011 de SHALL be 1 when h_cnt >= H_BLANK and v_cnt >= V_BLANK (BLANK = FP+SYNC+BP).
REQ-012 x = h_cnt-H_BLANK and y = v_cnt-V_BLANK while de; x = y = 0 otherwise.
REQ-013 sof SHALL pulse 1 clk coincident with de at x=0, y=0; eol SHALL pulse 1 clk with de at x = H_ACTIVE-1.
REQ-014 Active config SHALL be held in shadow registers; cfg_load captures cfg_* into pending set.
REQ-015 Pending set SHALL apply at frame end (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) or immediately while enable=0; cfg_load coinciding with frame end SHALL apply the newly loaded values.
REQ-016 Any zero field SHALL be treated as 1.
REQ-017 If H_TOTAL or V_TOTAL exceeds 2^CW-1 at capture, pending set SHALL be rejected, old config kept, cfg_err set until next accepted cfg_load.
REQ-018 enable=0 SHALL hold counters at 0 and drive hs/vs at inactive level, de/sof/eol = 0, x = y = 0; enable rise SHALL start at h_cnt=0, v_cnt=0.
REQ-019 Deasserting enable mid-frame SHALL abort the frame at the next clk; no partial-line completion.

Reset
REQ-020 rst SHALL clear counters, hs, vs, de, sof, eol, cfg_err to 0, x, y, rgb to 0.
REQ-021 rst SHALL load shadow and pending config with 1024x768 defaults: H 1024/24/136/160, V 768/3/6/29, both polarities 0.
REQ-022 First clk after rst release SHALL drive hs/vs at configured inactive level.

Configuration
REQ-023 Macro VTG_PATTERN_EN defined: rgb SHALL output 8 vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black), bar width = H_ACTIVE>>3 pixels, min 1, bar index saturating at 7, registered aligned with de; rgb = 0 when de=0.
REQ-024 Macro VTG_PATTERN_EN undefined: rgb SHALL be constant 0 and no pattern logic synthesised; all other behaviour unchanged.

Verification
REQ-025 Config H 4/1/1/1, V 2/1/1/1, pol 0, enable=1 -> H_TOTAL 7, V_TOTAL 5, 35-clk frame period, de high 4 clks per line on 2 lines, hs low 1 clk per line.
REQ-026 Same config -> sof once per 35 clks with x=0, y=0; eol on x=3 each active line; y sequence 0,1.
REQ-027 cfg_load with H_ACTIVE 8 mid-frame -> current frame keeps 4-pixel lines; next frame de high 8 clks per line.
REQ-028 cfg_load with cfg_h_active = 4095, CW=12 -> cfg_err=1, timing unchanged; subsequent valid cfg_load -> cfg_err=0.
REQ-029 enable dropped at v_cnt=3 -> next clk de=0, hs/vs inactive, x=y=0; re-enable -> first sof after V_BLANK lines plus H_BLANK+1 clks.
REQ-030 VTG_PATTERN_EN, H_ACTIVE 16 -> rgb FFFFFF for x 0-1, FFFF00 x 2-3, ... 000000 x 14-15; rgb 0 during blanking.
